// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the mem_arbiter and the shared memory.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;

  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;

  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter sharing one single-ported memory, one transaction in flight at a time.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        sel_d;
  logic        pick_d;
  logic        grant;
  logic        mem_wr_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] i_rdata_q;
  logic [15:0] d_rdata_q;

  if (LATENCY < 1) begin : g_latency_check
    $error("mem_arbiter: LATENCY must be at least 1");
  end

  assign grant = (state == IDLE) && (bus.i_req || bus.d_req);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // On a tie, the side that did not win the previous grant goes next.
  always_comb begin
    pick_d = bus.d_req && !(bus.i_req && last_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (grant) begin
      last_d <= pick_d;
    end
  end
`else
  always_comb begin
    pick_d = bus.d_req;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_req || bus.d_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = mem_wr_q ? DONE : WAIT;
      WAIT:    if (bus.mem_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command fields are latched at the grant edge so later requester changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_d       <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (grant) begin
        sel_d       <= pick_d;
        mem_wr_q    <= pick_d && bus.d_wr;
        mem_addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
        mem_wdata_q <= pick_d ? bus.d_wdata : 16'h0000;
      end
      if ((state == WAIT) && bus.mem_rvalid) begin
        if (sel_d) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          i_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_done    = (state == DONE) && !sel_d;
  assign bus.d_done    = (state == DONE) && sel_d;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reads, writes, ties, stray rvalid and reset mid-read.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   errors;

  logic       pend;
  logic       prev_en;
  int         consec;
  int         ng;
  logic [3:0] grants;
  logic [3:0] grants_exp;

  mem_arbiter_if bus ();

  mem_arbiter #(.LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_req = 1'b0;  bus.i_addr = '0;
    bus.d_req = 1'b0;  bus.d_wr = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
    bus.mem_rdata = '0;  bus.mem_rvalid = 1'b0;

    // reset state
    tick();
    tick();
    chk1 ("rst_mem_en", bus.mem_en, 1'b0);
    chk1 ("rst_mem_wr", bus.mem_wr, 1'b0);
    chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk16("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    chk1 ("rst_i_done", bus.i_done, 1'b0);
    chk1 ("rst_d_done", bus.d_done, 1'b0);
    chk16("rst_i_rdata", bus.i_rdata, 16'h0000);
    chk16("rst_d_rdata", bus.d_rdata, 16'h0000);
    chk1 ("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // fetch read, rvalid four cycles after issue
    bus.i_req = 1'b1;  bus.i_addr = 16'h0040;
    chk1 ("f_c0_busy", busy, 1'b0);
    tick();
    chk1 ("f_c1_mem_en", bus.mem_en, 1'b1);
    chk16("f_c1_addr", bus.mem_addr, 16'h0040);
    chk1 ("f_c1_wr", bus.mem_wr, 1'b0);
    chk16("f_c1_wdata", bus.mem_wdata, 16'h0000);
    bus.i_addr = 16'hFFFF;
    tick();
    chk1 ("f_c2_mem_en", bus.mem_en, 1'b0);
    tick();
    tick();
    tick();
    chk1 ("f_c5_i_done", bus.i_done, 1'b0);
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 16'hA5A5;
    tick();
    bus.mem_rvalid = 1'b0;
    chk1 ("f_c6_i_done", bus.i_done, 1'b1);
    chk16("f_c6_i_rdata", bus.i_rdata, 16'hA5A5);
    chk1 ("f_c6_d_done", bus.d_done, 1'b0);
    chk16("f_c6_addr_held", bus.mem_addr, 16'h0040);
    bus.i_req = 1'b0;
    tick();
    chk1 ("f_c7_i_done", bus.i_done, 1'b0);
    chk1 ("f_c7_busy", busy, 1'b0);

    // data write
    bus.d_req = 1'b1;  bus.d_wr = 1'b1;  bus.d_addr = 16'h1000;  bus.d_wdata = 16'h1234;
    tick();
    chk1 ("w_c1_mem_en", bus.mem_en, 1'b1);
    chk1 ("w_c1_wr", bus.mem_wr, 1'b1);
    chk16("w_c1_addr", bus.mem_addr, 16'h1000);
    chk16("w_c1_wdata", bus.mem_wdata, 16'h1234);
    tick();
    chk1 ("w_c2_d_done", bus.d_done, 1'b1);
    chk1 ("w_c2_i_done", bus.i_done, 1'b0);
    chk1 ("w_c2_mem_en", bus.mem_en, 1'b0);
    chk16("w_c2_d_rdata", bus.d_rdata, 16'h0000);
    bus.d_req = 1'b0;
    tick();
    chk1 ("w_c3_d_done", bus.d_done, 1'b0);
    chk1 ("w_c3_busy", busy, 1'b0);

    // data read, rvalid in the first WAIT cycle
    bus.d_req = 1'b1;  bus.d_wr = 1'b0;  bus.d_addr = 16'h2000;
    tick();
    chk1 ("dr_c1_mem_en", bus.mem_en, 1'b1);
    chk1 ("dr_c1_wr", bus.mem_wr, 1'b0);
    chk16("dr_c1_addr", bus.mem_addr, 16'h2000);
    tick();
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 16'h5A5A;
    tick();
    bus.mem_rvalid = 1'b0;
    chk1 ("dr_c3_d_done", bus.d_done, 1'b1);
    chk1 ("dr_c3_i_done", bus.i_done, 1'b0);
    chk16("dr_c3_d_rdata", bus.d_rdata, 16'h5A5A);
    chk16("dr_c3_i_rdata", bus.i_rdata, 16'hA5A5);
    bus.d_req = 1'b0;
    tick();
    chk1 ("dr_c4_d_done", bus.d_done, 1'b0);

    // stray rvalid while idle
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 16'hDEAD;
    tick();
    tick();
    chk16("stray_i_rdata", bus.i_rdata, 16'hA5A5);
    chk16("stray_d_rdata", bus.d_rdata, 16'h5A5A);
    chk1 ("stray_i_done", bus.i_done, 1'b0);
    chk1 ("stray_d_done", bus.d_done, 1'b0);
    chk1 ("stray_busy", busy, 1'b0);
    bus.mem_rvalid = 1'b0;

    // tie: data first, fetch after d_done
    bus.i_req = 1'b1;  bus.i_addr = 16'h0100;
    bus.d_req = 1'b1;  bus.d_wr = 1'b1;  bus.d_addr = 16'h0200;  bus.d_wdata = 16'h7777;
    tick();
    chk16("tie_c1_addr", bus.mem_addr, 16'h0200);
    chk1 ("tie_c1_wr", bus.mem_wr, 1'b1);
    tick();
    chk1 ("tie_c2_d_done", bus.d_done, 1'b1);
    chk1 ("tie_c2_i_done", bus.i_done, 1'b0);
    bus.d_req = 1'b0;
    tick();
    chk1 ("tie_c3_busy", busy, 1'b0);
    tick();
    chk1 ("tie_c4_mem_en", bus.mem_en, 1'b1);
    chk16("tie_c4_addr", bus.mem_addr, 16'h0100);
    chk1 ("tie_c4_wr", bus.mem_wr, 1'b0);
    chk16("tie_c4_wdata", bus.mem_wdata, 16'h0000);
    tick();
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 16'h1111;
    tick();
    bus.mem_rvalid = 1'b0;
    chk1 ("tie_c6_i_done", bus.i_done, 1'b1);
    chk16("tie_c6_i_rdata", bus.i_rdata, 16'h1111);
    chk16("tie_c6_d_rdata", bus.d_rdata, 16'h5A5A);
    bus.i_req = 1'b0;
    tick();

    // both requests held: record the first four grants
    bus.i_req = 1'b1;  bus.i_addr = 16'h0400;
    bus.d_req = 1'b1;  bus.d_wr = 1'b1;  bus.d_addr = 16'h0300;  bus.d_wdata = 16'h0303;
    pend = 1'b0;  prev_en = 1'b0;  consec = 0;  ng = 0;  grants = '0;
    for (int c = 0; c < 60; c++) begin
      tick();
      bus.mem_rvalid = pend;
      bus.mem_rdata  = 16'h0404;
      pend = 1'b0;
      if (bus.mem_en && prev_en) consec++;
      prev_en = bus.mem_en;
      if (bus.mem_en) begin
        if (ng < 4) grants[2'(ng)] = (bus.mem_addr == 16'h0300);
        ng++;
        pend = !bus.mem_wr;
        if (ng == 4) begin
          bus.i_req = 1'b0;
          bus.d_req = 1'b0;
        end
      end
      if (ng >= 4 && !busy) break;
    end
    bus.mem_rvalid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    grants_exp = 4'b0101;
`else
    grants_exp = 4'b1111;
`endif
    chk16("hold_grant_count", 16'(ng), 16'd4);
    chk16("hold_grant_order", {12'h000, grants}, {12'h000, grants_exp});
    chk16("hold_consec_en", 16'(consec), 16'd0);
    chk1 ("hold_idle_after", busy, 1'b0);

    // back-to-back fetches with i_req held
    bus.i_req = 1'b1;  bus.i_addr = 16'h0500;
    tick();
    chk1 ("b2b_c1_mem_en", bus.mem_en, 1'b1);
    tick();
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 16'hBEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk1 ("b2b_c3_i_done", bus.i_done, 1'b1);
    chk16("b2b_c3_i_rdata", bus.i_rdata, 16'hBEEF);
    chk1 ("b2b_c3_mem_en", bus.mem_en, 1'b0);
    tick();
    chk1 ("b2b_c4_mem_en", bus.mem_en, 1'b0);
    chk1 ("b2b_c4_i_done", bus.i_done, 1'b0);
    chk1 ("b2b_c4_busy", busy, 1'b0);
    tick();
    chk1 ("b2b_c5_mem_en", bus.mem_en, 1'b1);
    chk16("b2b_c5_addr", bus.mem_addr, 16'h0500);
    bus.i_req = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 16'hC0DE;
    tick();
    bus.mem_rvalid = 1'b0;
    chk1 ("b2b_c7_i_done", bus.i_done, 1'b1);
    chk16("b2b_c7_i_rdata", bus.i_rdata, 16'hC0DE);
    tick();

    // reset asserted mid-read, stale rvalid after release
    bus.i_req = 1'b1;  bus.i_addr = 16'h0600;
    tick();
    tick();
    chk1 ("rr_c2_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1 ("rr_busy", busy, 1'b0);
    chk1 ("rr_mem_en", bus.mem_en, 1'b0);
    chk1 ("rr_mem_wr", bus.mem_wr, 1'b0);
    chk16("rr_mem_addr", bus.mem_addr, 16'h0000);
    chk16("rr_mem_wdata", bus.mem_wdata, 16'h0000);
    chk16("rr_i_rdata", bus.i_rdata, 16'h0000);
    chk16("rr_d_rdata", bus.d_rdata, 16'h0000);
    chk1 ("rr_i_done", bus.i_done, 1'b0);
    chk1 ("rr_d_done", bus.d_done, 1'b0);
    bus.i_req = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 16'h9999;
    tick();
    chk1 ("rr_post1_i_done", bus.i_done, 1'b0);
    tick();
    bus.mem_rvalid = 1'b0;
    chk1 ("rr_post2_i_done", bus.i_done, 1'b0);
    chk1 ("rr_post2_d_done", bus.d_done, 1'b0);
    chk16("rr_post2_i_rdata", bus.i_rdata, 16'h0000);
    chk16("rr_post2_d_rdata", bus.d_rdata, 16'h0000);
    chk1 ("rr_post2_busy", busy, 1'b0);
    tick();
    chk1 ("rr_post3_mem_en", bus.mem_en, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
